// File: rtl/uart_move_rx_if.sv
// uart_move_rx_if: serial line plus received-byte outputs of uart_move_rx.
// The master side drives the serial line. The slave side is the receiver.
interface uart_move_rx_if #(
    parameter int PKT_LEN = 8
);
    logic               rx;
    logic               ready;
    logic [PKT_LEN-1:0] data_out;
    logic               frame_err;
    logic               busy;

    modport master (
        output rx,
        input  ready,
        input  data_out,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  rx,
        output ready,
        output data_out,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_move_rx.sv
// uart_move_rx: oversampling UART receiver for move bytes.
// The frame is 1 start bit, PKT_LEN data bits (LSB first) and 1 stop bit.
// Each bit is a 3-sample majority vote around mid-bit.
// The FSM returns to IDLE early, in the middle of the stop bit, so a start
// edge that follows immediately is not missed.
// Optional feature: define RX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit.
// Requirements: PKT_LEN >= 2, SAMP_PER_BIT in 8..64, CLK_PER_SAMP >= 2.
module uart_move_rx #(
    parameter int CLK_PER_SAMP = 423,
    parameter int SAMP_PER_BIT = 16,
    parameter int PKT_LEN      = 8
) (
    input  logic          clk_in,
    input  logic          rst_in,
    uart_move_rx_if.slave bus
);

    localparam int TCW = (CLK_PER_SAMP > 1) ? $clog2(CLK_PER_SAMP) : 1;
    localparam int SCW = $clog2(SAMP_PER_BIT);
    localparam int BCW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    // Sample indices used for voting and for the bit-period boundary.
    localparam logic [SCW-1:0] IDX_LO   = SCW'(SAMP_PER_BIT / 2 - 1);
    localparam logic [SCW-1:0] IDX_MID  = SCW'(SAMP_PER_BIT / 2);
    localparam logic [SCW-1:0] IDX_HI   = SCW'(SAMP_PER_BIT / 2 + 1);
    localparam logic [SCW-1:0] IDX_END  = SCW'(SAMP_PER_BIT - 1);
    localparam logic [TCW-1:0] TICK_END = TCW'(CLK_PER_SAMP - 1);
    localparam logic [BCW-1:0] BIT_END  = BCW'(PKT_LEN - 1);

    if (SAMP_PER_BIT < 8 || SAMP_PER_BIT > 64) begin : g_bad_samp
        $error("uart_move_rx: SAMP_PER_BIT must be within 8..64");
    end

`ifdef RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             state_q, state_d;

    logic               sync1_q, sync2_q;
    logic               line;

    logic [TCW-1:0]     tick_cnt_q;
    logic [SCW-1:0]     samp_cnt_q;
    logic               tick;
    logic               at_lo, at_mid, at_hi, at_end;

    logic [PKT_LEN-1:0] shift_q, shift_d;
    logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]         vote_q, vote_d;
    logic               vote_now;
    logic               frame_ok;
    logic               ready_q, ready_d;
    logic               ferr_q, ferr_d;
    logic [PKT_LEN-1:0] data_q, data_d;
`ifdef RX_PARITY_EN
    logic               par_err_q, par_err_d;
`endif

    // 2-of-3 majority used for every bit decision.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Bring the asynchronous line into the clk_in domain. The flops idle high like the line.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    assign line = sync2_q;

    // Oversample timebase. Both counters stay at zero in IDLE, so each START begins a fresh bit period.
    always_ff @(posedge clk_in) begin
        if (rst_in || state_q == S_IDLE) begin
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
        end else if (tick) begin
            tick_cnt_q <= '0;
            samp_cnt_q <= (samp_cnt_q == IDX_END) ? '0 : samp_cnt_q + SCW'(1);
        end else begin
            tick_cnt_q <= tick_cnt_q + TCW'(1);
        end
    end

    assign tick   = (state_q != S_IDLE) && (tick_cnt_q == TICK_END);
    assign at_lo  = tick && (samp_cnt_q == IDX_LO);
    assign at_mid = tick && (samp_cnt_q == IDX_MID);
    assign at_hi  = tick && (samp_cnt_q == IDX_HI);
    assign at_end = tick && (samp_cnt_q == IDX_END);

    // The first two votes are registered. The third is the live line at IDX_HI.
    assign vote_now = maj3(vote_q[1], vote_q[0], line);

`ifdef RX_PARITY_EN
    assign frame_ok = vote_now && !par_err_q;
`else
    assign frame_ok = vote_now;
`endif

    // Next-state and datapath decisions. The result pulses are registered, so they appear the cycle after the stop vote.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        vote_d    = vote_q;
        ready_d   = 1'b0;
        ferr_d    = 1'b0;
        data_d    = data_q;
`ifdef RX_PARITY_EN
        par_err_d = par_err_q;
`endif

        if (at_lo) begin
            vote_d[1] = line;
        end
        if (at_mid) begin
            vote_d[0] = line;
        end

        case (state_q)
            S_IDLE: begin
                if (!line) begin
                    state_d   = S_START;
                    bit_cnt_d = '0;
                end
            end
            S_START: begin
                if (at_hi && vote_now) begin
                    state_d = S_IDLE;
                end else if (at_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (at_hi) begin
                    shift_d = {vote_now, shift_q[PKT_LEN-1:1]};
                end
                if (at_end) begin
                    if (bit_cnt_q == BIT_END) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (at_hi) begin
                    par_err_d = vote_now ^ (^shift_q);
                end
                if (at_end) begin
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (at_hi) begin
                    state_d = S_IDLE;
                    if (frame_ok) begin
                        ready_d = 1'b1;
                        data_d  = shift_q;
                    end else begin
                        ferr_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any partial frame without a pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            vote_q    <= '0;
            ready_q   <= 1'b0;
            ferr_q    <= 1'b0;
            data_q    <= '0;
`ifdef RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            vote_q    <= vote_d;
            ready_q   <= ready_d;
            ferr_q    <= ferr_d;
            data_q    <= data_d;
`ifdef RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign bus.ready     = ready_q;
    assign bus.frame_err = ferr_q;
    assign bus.data_out  = data_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule
